// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with valid/ready request and response ports.
module muldiv_seq #(
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [DWIDTH-1:0] req_a,
  input  logic [DWIDTH-1:0] req_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DWIDTH-1:0] resp_data,
  output logic              busy,
  input  logic              kill
);

  localparam int unsigned CW = $clog2(DWIDTH);
  localparam int unsigned PW = 2 * DWIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [DWIDTH-1:0] hi, hi_d;
  logic [DWIDTH-1:0] lo, lo_d;
  logic [DWIDTH-1:0] opb, opb_d;
  logic [2:0]        f3, f3_d;
  logic              sa, sa_d;
  logic              sb, sb_d;
  logic [DWIDTH-1:0] resp_data_d;

  // Request decode: operand signedness, magnitudes and RISC-V special cases
  logic              req_is_div, req_a_signed, req_b_signed;
  logic              req_neg_a, req_neg_b, div_zero, div_ovf;
  logic [DWIDTH-1:0] a_mag, b_mag;

  assign req_is_div   = req_funct3[2];
  assign req_a_signed = req_is_div ? ~req_funct3[0] : (req_funct3[1:0] != 2'b11);
  assign req_b_signed = req_is_div ? ~req_funct3[0] : ~req_funct3[1];
  assign req_neg_a    = req_a_signed & req_a[DWIDTH-1];
  assign req_neg_b    = req_b_signed & req_b[DWIDTH-1];
  assign a_mag        = req_neg_a ? (~req_a + DWIDTH'(1)) : req_a;
  assign b_mag        = req_neg_b ? (~req_b + DWIDTH'(1)) : req_b;
  assign div_zero     = req_is_div && (req_b == '0);
  assign div_ovf      = req_is_div && !req_funct3[0] &&
                        (req_a == {1'b1, {(DWIDTH-1){1'b0}}}) && (req_b == '1);

  // One iteration of each algorithm on the shared hi/lo accumulator
  logic [DWIDTH:0]   mul_sum, div_shift, div_diff;
  logic [PW-1:0]     prod_fix;
  logic [DWIDTH-1:0] q_fix, r_fix, fix_word;

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    div_shift = {hi, lo[DWIDTH-1]};
    div_diff  = div_shift - {1'b0, opb};
    prod_fix  = (sa ^ sb) ? (~{hi, lo} + PW'(1)) : {hi, lo};
    q_fix     = (sa ^ sb) ? (~lo + DWIDTH'(1)) : lo;
    r_fix     = sa ? (~hi + DWIDTH'(1)) : hi;
    if (!f3[2])
      fix_word = (f3[1:0] == 2'b00) ? prod_fix[DWIDTH-1:0] : prod_fix[PW-1:DWIDTH];
    else
      fix_word = f3[1] ? r_fix : q_fix;
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    hi_d        = hi;
    lo_d        = lo;
    opb_d       = opb;
    f3_d        = f3;
    sa_d        = sa;
    sb_d        = sb;
    resp_data_d = resp_data;

    case (state)
      S_IDLE: begin
        if (req_valid && !kill) begin
          f3_d  = req_funct3;
          sa_d  = req_neg_a;
          sb_d  = req_neg_b;
          cnt_d = '0;
          hi_d  = '0;
          if (div_zero) begin
            resp_data_d = req_funct3[1] ? req_a : '1;
            state_d     = S_DONE;
          end else if (div_ovf) begin
            resp_data_d = req_funct3[1] ? '0 : req_a;
            state_d     = S_DONE;
          end else begin
            lo_d    = req_is_div ? a_mag : b_mag;
            opb_d   = req_is_div ? b_mag : a_mag;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt + CW'(1);
        if (!f3[2]) begin
          hi_d = mul_sum[DWIDTH:1];
          lo_d = {mul_sum[0], lo[DWIDTH-1:1]};
        end else if (!div_diff[DWIDTH]) begin
          hi_d = div_diff[DWIDTH-1:0];
          lo_d = {lo[DWIDTH-2:0], 1'b1};
        end else begin
          hi_d = div_shift[DWIDTH-1:0];
          lo_d = {lo[DWIDTH-2:0], 1'b0};
        end
        if (cnt == CW'(DWIDTH - 1))
          state_d = S_FIXUP;
      end
      S_FIXUP: begin
        resp_data_d = fix_word;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (resp_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush wins over everything, including a DONE handshake
    if (kill)
      state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      opb       <= '0;
      f3        <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      resp_data <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      hi        <= hi_d;
      lo        <= lo_d;
      opb       <= opb_d;
      f3        <= f3_d;
      sa        <= sa_d;
      sb        <= sb_d;
      resp_data <= resp_data_d;
    end
  end

  // Handshake flags decode straight from the state register
  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_DONE);
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed RV32M vectors, special cases,
// backpressure, kill and asynchronous reset.
module tb_muldiv_seq;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic        busy;
  logic        kill = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  muldiv_seq #(.DWIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .busy(busy), .kill(kill)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake pops one expected result
  initial begin
    logic [31:0] e;
    string nm;
    forever begin
      @(negedge clk);
      if (!rst && resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_resp: got %h want none", resp_data);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          check(nm, resp_data, e);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    @(negedge clk);
    while (!resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic scramble();
    req_a      = $urandom;
    req_b      = $urandom;
    req_funct3 = 3'($urandom);
  endtask

  task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    wait_ready();
    req_valid  = 1'b1;
    req_funct3 = f;
    req_a      = a;
    req_b      = b;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(posedge clk);
    #1 req_valid = 1'b0;
    scramble();
    wait_resp(lat);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int n;
    repeat (3) @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_data", resp_data, 32'd0);
    rst = 1'b0;

    // Multiply family
    do_op("mul_7x-3",    F_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    do_op("mulhu_max",   F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    do_op("mulh_min",    F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    do_op("mulhsu_m1",   F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    do_op("mul_min_m1",  F_MUL,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);

    // Divide family
    do_op("div_-7_2",    F_DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
    do_op("rem_-7_2",    F_REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
    do_op("divu_100_7",  F_DIVU,   32'd100,       32'd7,        32'd14,        33);
    do_op("remu_100_7",  F_REMU,   32'd100,       32'd7,        32'd2,         33);
    do_op("div_7_-2",    F_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);

    // Special cases complete the cycle after accept
    do_op("divu_by0",    F_DIVU,   32'h0000_1234, 32'd0,        32'hFFFF_FFFF, 0);
    do_op("rem_by0",     F_REM,    32'h0000_1234, 32'd0,        32'h0000_1234, 0);
    do_op("remu_by0",    F_REMU,   32'd5,         32'd0,        32'd5,         0);
    do_op("div_ovf",     F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    do_op("rem_ovf",     F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0);

    // Backpressure in DONE with a request waiting
    wait_ready();
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_funct3 = F_DIVU;
    req_a      = 32'd100;
    req_b      = 32'd7;
    exp_q.push_back(32'd14);
    name_q.push_back("bp_divu");
    @(posedge clk);
    #1 req_valid = 1'b0;
    scramble();
    wait_resp(lat);
    check("bp_divu_latency", 32'(lat), 32'd33);
    req_valid  = 1'b1;
    req_funct3 = F_MUL;
    req_a      = 32'd3;
    req_b      = 32'd4;
    exp_q.push_back(32'd12);
    name_q.push_back("bp_mul");
    for (int i = 0; i < 5; i++) begin
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      check("bp_resp_data", resp_data, 32'd14);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(negedge clk);
    check("bp_req_ready_hs", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("bp_req_ready_after", 32'(req_ready), 32'd1);
    check("bp_resp_valid_after", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    scramble();
    wait_resp(lat);
    check("bp_mul_latency", 32'(lat), 32'd33);

    // kill at counter = 10 discards the operation
    wait_ready();
    req_valid  = 1'b1;
    req_funct3 = F_MUL;
    req_a      = 32'd5;
    req_b      = 32'd6;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    check("kill_busy", 32'(busy), 32'd0);
    check("kill_resp_valid", 32'(resp_valid), 32'd0);
    check("kill_req_ready", 32'(req_ready), 32'd1);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid) n++;
    end
    check("kill_no_resp", 32'(n), 32'd0);

    // kill together with a request in IDLE blocks the accept
    req_valid  = 1'b1;
    kill       = 1'b1;
    req_funct3 = F_DIVU;
    req_a      = 32'd9;
    req_b      = 32'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    kill = 1'b0;
    @(negedge clk);
    check("kill_acc_busy", 32'(busy), 32'd0);
    check("kill_acc_resp_valid", 32'(resp_valid), 32'd0);

    // Asynchronous reset mid-CALC
    wait_ready();
    req_valid  = 1'b1;
    req_funct3 = F_MULHU;
    req_a      = 32'h1234_5678;
    req_b      = 32'h9ABC_DEF0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_resp_valid", 32'(resp_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd1);
    check("arst_resp_data", resp_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op("mul_3x4_after_rst", F_MUL, 32'd3, 32'd4, 32'd12, 33);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
